// File: rtl/iram_arb.sv
// rtl/iram_arb.sv - round-robin arbiter with debug lock for the IRAM data port
//
// Shares one synchronous, single-cycle RAM port between the core load/store
// path (m0) and the JTAG debug module (m1).
//   clk, rst            : clock, synchronous active-high reset
//   mX_req/we/addr/     : request, write flag, word address,
//   wdata/wem           :   write data and byte write enables
//   mX_gnt              : request accepted this cycle
//   mX_rvalid/rdata     : one-cycle response pulse and read data
//   m1_lock, lock_ack   : debugger exclusive-ownership handshake
//   ram_en/we/addr/din  : RAM port drive
//   ram_dout            : RAM read data, valid the cycle after ram_en
module iram_arb #(
  parameter int AW = 15,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wem,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [DW-1:0]   m0_rdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wem,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [DW-1:0]   m1_rdata,
  input  logic            m1_lock,
  output logic            lock_ack,
  output logic            ram_en,
  output logic [DW/8-1:0] ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_din,
  input  logic [DW-1:0]   ram_dout
);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_valid_q, owner_valid_d;
  logic          owner_id_q, owner_id_d;
  logic          owner_rd_q, owner_rd_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;

  logic g0, g1;
  logic rd_resp0, rd_resp1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ARB;
      last_q        <= 1'b1;
      owner_valid_q <= 1'b0;
      owner_id_q    <= 1'b0;
      owner_rd_q    <= 1'b0;
      m0_rdata_q    <= '0;
      m1_rdata_q    <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_valid_q <= owner_valid_d;
      owner_id_q    <= owner_id_d;
      owner_rd_q    <= owner_rd_d;
      m0_rdata_q    <= m0_rdata_d;
      m1_rdata_q    <= m1_rdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ARB:  if (m1_lock)  state_d = ST_LOCK;
      ST_LOCK: if (!m1_lock) state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    // m0 is fenced off as soon as m1_lock is seen, before LOCK is entered.
    // The master other than last_q wins a contested cycle.
    g0 = !rst && m0_req && (state_q == ST_ARB) && !m1_lock && (!m1_req || last_q);
    g1 = !rst && m1_req && !g0;

    last_d = last_q;
    if (g0)      last_d = 1'b0;
    else if (g1) last_d = 1'b1;
    // Leaving LOCK hands the next contested cycle to the core.
    if (state_q == ST_LOCK && !m1_lock) last_d = 1'b1;

    owner_valid_d = g0 | g1;
    owner_id_d    = g1;
    owner_rd_d    = g1 ? !m1_we : !m0_we;

    ram_en   = g0 | g1;
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = '0;
    if (g0) begin
      ram_addr = m0_addr;
      ram_din  = m0_wdata;
      ram_we   = m0_we ? m0_wem : '0;
    end else if (g1) begin
      ram_addr = m1_addr;
      ram_din  = m1_wdata;
      ram_we   = m1_we ? m1_wem : '0;
    end

    // Responses are masked during reset so an access granted just before
    // reset never reports.
    m0_rvalid = !rst && owner_valid_q && !owner_id_q;
    m1_rvalid = !rst && owner_valid_q && owner_id_q;
    rd_resp0  = m0_rvalid && owner_rd_q;
    rd_resp1  = m1_rvalid && owner_rd_q;

    // Read data is forwarded from the RAM on the response cycle and held.
    m0_rdata_d = rd_resp0 ? ram_dout : m0_rdata_q;
    m1_rdata_d = rd_resp1 ? ram_dout : m1_rdata_q;
    m0_rdata   = rst ? '0 : m0_rdata_d;
    m1_rdata   = rst ? '0 : m1_rdata_d;

    m0_gnt   = g0;
    m1_gnt   = g1;
    lock_ack = !rst && (state_q == ST_LOCK);
  end

endmodule

// File: tb/tb_iram_arb.sv
// tb/tb_iram_arb.sv - self-checking bench for iram_arb
module tb_iram_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [14:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wem, m1_wem;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, lock_ack, ram_en;
  logic [31:0] m0_rdata, m1_rdata, ram_din;
  logic [31:0] ram_dout = 32'h0;
  logic [3:0]  ram_we;
  logic [14:0] ram_addr;

  logic [31:0] mem [0:32767];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iram_arb #(.AW(15), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wem(m0_wem),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wem(m1_wem),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .m1_lock(m1_lock), .lock_ack(lock_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Read-first synchronous RAM with byte enables
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
    end
  end

  typedef struct {
    logic        rst;
    logic        r0, w0; logic [14:0] a0; logic [31:0] d0; logic [3:0] e0;
    logic        r1, w1; logic [14:0] a1; logic [31:0] d1; logic [3:0] e1;
    logic        lk;
    logic        x_g0, x_g1, x_v0, x_v1;
    logic [31:0] x_rd0, x_rd1;
    logic        x_lack, x_en;
    logic [3:0]  x_we; logic [14:0] x_addr; logic [31:0] x_din;
  } vec_t;

  vec_t tab [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; m1_lock = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wem = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wem = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
    mem[15'h10] = 32'h12345678;
    mem[15'h20] = 32'h11223344;
    mem[15'h30] = 32'hCAFEF00D;
    idle();
    rst = 1'b1;

    //          rst r0 w0 a0      d0            e0    r1 w1 a1      d1            e1    lk g0 g1 v0 v1 rd0           rd1           la en we    addr    din
    tab[0]  = '{1, 1, 0, 15'h10, 32'h0,        4'hF, 1, 0, 15'h30, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 4'h0, 15'h0,  32'h0};
    tab[1]  = '{1, 1, 0, 15'h10, 32'h0,        4'hF, 1, 0, 15'h30, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 4'h0, 15'h0,  32'h0};
    tab[2]  = '{1, 1, 0, 15'h10, 32'h0,        4'hF, 1, 0, 15'h30, 32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 4'h0, 15'h0,  32'h0};
    tab[3]  = '{0, 1, 0, 15'h10, 32'h0,        4'hF, 1, 0, 15'h30, 32'h0,        4'h0, 0, 1, 0, 0, 0, 32'h0,        32'h0,        0, 1, 4'h0, 15'h10, 32'h0};
    tab[4]  = '{0, 0, 0, 15'h0,  32'h0,        4'h0, 1, 0, 15'h30, 32'h0,        4'h0, 0, 0, 1, 1, 0, 32'h12345678, 32'h0,        0, 1, 4'h0, 15'h30, 32'h0};
    tab[5]  = '{0, 0, 0, 15'h0,  32'h0,        4'h0, 0, 0, 15'h0,  32'h0,        4'h0, 0, 0, 0, 0, 1, 32'h12345678, 32'hCAFEF00D, 0, 0, 4'h0, 15'h0,  32'h0};
    tab[6]  = '{0, 0, 0, 15'h0,  32'h0,        4'h0, 0, 0, 15'h0,  32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h12345678, 32'hCAFEF00D, 0, 0, 4'h0, 15'h0,  32'h0};
    tab[7]  = '{0, 1, 0, 15'h10, 32'hA0A0A0A0, 4'h0, 1, 0, 15'h30, 32'h0B0B0B0B, 4'h0, 0, 1, 0, 0, 0, 32'h12345678, 32'hCAFEF00D, 0, 1, 4'h0, 15'h10, 32'hA0A0A0A0};
    tab[8]  = '{0, 1, 0, 15'h10, 32'hA0A0A0A0, 4'h0, 1, 0, 15'h30, 32'h0B0B0B0B, 4'h0, 0, 0, 1, 1, 0, 32'h12345678, 32'hCAFEF00D, 0, 1, 4'h0, 15'h30, 32'h0B0B0B0B};
    tab[9]  = '{0, 1, 0, 15'h10, 32'hA0A0A0A0, 4'h0, 1, 0, 15'h30, 32'h0B0B0B0B, 4'h0, 0, 1, 0, 0, 1, 32'h12345678, 32'hCAFEF00D, 0, 1, 4'h0, 15'h10, 32'hA0A0A0A0};
    tab[10] = '{0, 1, 0, 15'h10, 32'hA0A0A0A0, 4'h0, 1, 0, 15'h30, 32'h0B0B0B0B, 4'h0, 0, 0, 1, 1, 0, 32'h12345678, 32'hCAFEF00D, 0, 1, 4'h0, 15'h30, 32'h0B0B0B0B};
    tab[11] = '{0, 1, 0, 15'h10, 32'hA0A0A0A0, 4'h0, 1, 0, 15'h30, 32'h0B0B0B0B, 4'h0, 0, 1, 0, 0, 1, 32'h12345678, 32'hCAFEF00D, 0, 1, 4'h0, 15'h10, 32'hA0A0A0A0};
    tab[12] = '{0, 1, 0, 15'h10, 32'hA0A0A0A0, 4'h0, 1, 0, 15'h30, 32'h0B0B0B0B, 4'h0, 0, 0, 1, 1, 0, 32'h12345678, 32'hCAFEF00D, 0, 1, 4'h0, 15'h30, 32'h0B0B0B0B};
    tab[13] = '{0, 0, 0, 15'h0,  32'h0,        4'h0, 0, 0, 15'h0,  32'h0,        4'h0, 0, 0, 0, 0, 1, 32'h12345678, 32'hCAFEF00D, 0, 0, 4'h0, 15'h0,  32'h0};
    tab[14] = '{0, 0, 0, 15'h0,  32'h0,        4'h0, 1, 1, 15'h20, 32'h0000AB00, 4'h2, 0, 0, 1, 0, 0, 32'h12345678, 32'hCAFEF00D, 0, 1, 4'h2, 15'h20, 32'h0000AB00};
    tab[15] = '{0, 0, 0, 15'h0,  32'h0,        4'h0, 1, 0, 15'h20, 32'h0,        4'h2, 0, 0, 1, 0, 1, 32'h12345678, 32'hCAFEF00D, 0, 1, 4'h0, 15'h20, 32'h0};
    tab[16] = '{0, 0, 0, 15'h0,  32'h0,        4'h0, 0, 0, 15'h0,  32'h0,        4'h0, 0, 0, 0, 0, 1, 32'h12345678, 32'h1122AB44, 0, 0, 4'h0, 15'h0,  32'h0};
    tab[17] = '{0, 0, 0, 15'h0,  32'h0,        4'h0, 0, 0, 15'h0,  32'h0,        4'h0, 0, 0, 0, 0, 0, 32'h12345678, 32'h1122AB44, 0, 0, 4'h0, 15'h0,  32'h0};

    next_cycle();

    for (int i = 0; i < 18; i++) begin
      rst = tab[i].rst; m1_lock = tab[i].lk;
      m0_req = tab[i].r0; m0_we = tab[i].w0; m0_addr = tab[i].a0; m0_wdata = tab[i].d0; m0_wem = tab[i].e0;
      m1_req = tab[i].r1; m1_we = tab[i].w1; m1_addr = tab[i].a1; m1_wdata = tab[i].d1; m1_wem = tab[i].e1;
      @(negedge clk);
      chk($sformatf("v%0d m0_gnt", i),    32'(m0_gnt),    32'(tab[i].x_g0));
      chk($sformatf("v%0d m1_gnt", i),    32'(m1_gnt),    32'(tab[i].x_g1));
      chk($sformatf("v%0d m0_rvalid", i), 32'(m0_rvalid), 32'(tab[i].x_v0));
      chk($sformatf("v%0d m1_rvalid", i), 32'(m1_rvalid), 32'(tab[i].x_v1));
      chk($sformatf("v%0d m0_rdata", i),  m0_rdata,       tab[i].x_rd0);
      chk($sformatf("v%0d m1_rdata", i),  m1_rdata,       tab[i].x_rd1);
      chk($sformatf("v%0d lock_ack", i),  32'(lock_ack),  32'(tab[i].x_lack));
      chk($sformatf("v%0d ram_en", i),    32'(ram_en),    32'(tab[i].x_en));
      chk($sformatf("v%0d ram_we", i),    32'(ram_we),    32'(tab[i].x_we));
      chk($sformatf("v%0d ram_addr", i),  32'(ram_addr),  32'(tab[i].x_addr));
      chk($sformatf("v%0d ram_din", i),   ram_din,        tab[i].x_din);
      next_cycle();
    end

    // Lock entry: m0 fenced off in the cycle m1_lock rises
    idle();
    m0_req = 1'b1; m0_addr = 15'h10; m1_lock = 1'b1;
    @(negedge clk);
    chk("L0 m0_gnt", 32'(m0_gnt), 32'h0);
    chk("L0 lock_ack", 32'(lock_ack), 32'h0);
    chk("L0 ram_en", 32'(ram_en), 32'h0);
    next_cycle();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 15'h0; m1_wdata = 32'hDEADBEEF; m1_wem = 4'hF;
    @(negedge clk);
    chk("L1 lock_ack", 32'(lock_ack), 32'h1);
    chk("L1 m0_gnt", 32'(m0_gnt), 32'h0);
    chk("L1 m1_gnt", 32'(m1_gnt), 32'h1);
    chk("L1 ram_we", 32'(ram_we), 32'hF);
    chk("L1 ram_din", ram_din, 32'hDEADBEEF);
    next_cycle();
    m1_addr = 15'h1; m1_wdata = 32'h01020304;
    @(negedge clk);
    chk("L2 m1_gnt", 32'(m1_gnt), 32'h1);
    chk("L2 m1_rvalid", 32'(m1_rvalid), 32'h1);
    chk("L2 m0_gnt", 32'(m0_gnt), 32'h0);
    next_cycle();
    // Lock release in the same cycle as an m1 request
    m1_lock = 1'b0; m1_we = 1'b0; m1_addr = 15'h0; m1_wdata = 32'h0; m1_wem = 4'h0;
    @(negedge clk);
    chk("L3 m1_gnt", 32'(m1_gnt), 32'h1);
    chk("L3 m0_gnt", 32'(m0_gnt), 32'h0);
    chk("L3 lock_ack", 32'(lock_ack), 32'h1);
    chk("L3 m1_rvalid", 32'(m1_rvalid), 32'h1);
    next_cycle();
    m1_addr = 15'h1;
    @(negedge clk);
    chk("L4 lock_ack", 32'(lock_ack), 32'h0);
    chk("L4 m0_gnt", 32'(m0_gnt), 32'h1);
    chk("L4 m1_gnt", 32'(m1_gnt), 32'h0);
    chk("L4 m1_rvalid", 32'(m1_rvalid), 32'h1);
    chk("L4 m1_rdata", m1_rdata, 32'hDEADBEEF);
    next_cycle();
    m0_req = 1'b0; m0_addr = 15'h0;
    @(negedge clk);
    chk("L5 m1_gnt", 32'(m1_gnt), 32'h1);
    chk("L5 m0_rvalid", 32'(m0_rvalid), 32'h1);
    chk("L5 m0_rdata", m0_rdata, 32'h12345678);
    next_cycle();
    idle();
    @(negedge clk);
    chk("L6 m1_rvalid", 32'(m1_rvalid), 32'h1);
    chk("L6 m1_rdata", m1_rdata, 32'h01020304);
    next_cycle();

    // Reset asserted the cycle after an m0 grant
    m0_req = 1'b1; m0_addr = 15'h20;
    @(negedge clk);
    chk("R0 m0_gnt", 32'(m0_gnt), 32'h1);
    next_cycle();
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("R1 m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("R1 m0_rdata", m0_rdata, 32'h0);
    chk("R1 ram_en", 32'(ram_en), 32'h0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("R2 m0_rvalid", 32'(m0_rvalid), 32'h0);
    chk("R2 m0_rdata", m0_rdata, 32'h0);
    chk("R2 m1_rdata", m1_rdata, 32'h0);
    chk("R2 lock_ack", 32'(lock_ack), 32'h0);
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
